// File: rtl/fnd_rank_scheduler.sv
// Rotates the FND display through the non-zero ranking registers and shows the
// live value for a while whenever it changes.
module fnd_rank_scheduler #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned RANK_HOLD = 3,
  parameter int unsigned LIVE_HOLD = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] slv_reg0,
  input  logic [7:0] slv_reg1,
  input  logic [7:0] slv_reg2,
  input  logic [7:0] slv_reg3,
  output logic [7:0] disp_data,
  output logic [1:0] disp_sel,
  output logic       tick
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = 4;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] RANK_LAST = HW'(RANK_HOLD - 1);
  localparam logic [HW-1:0] LIVE_LAST = HW'(LIVE_HOLD - 1);

  typedef enum logic [2:0] {IDLE, RANK1, RANK2, RANK3, LIVE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    ret_q, ret_d;
  logic [7:0]    shadow_q, shadow_d;
  logic          valid_q, valid_d;
  logic [7:0]    disp_data_q, disp_data_d;
  logic [1:0]    disp_sel_q, disp_sel_d;

  logic [3:0]    nz;
  logic          live_chg;
  logic [1:0]    cur_idx;
  logic          rank_exp;
  logic          live_exp;

  // Next non-zero rank after n in cyclic order, n itself last; 0 when none.
  function automatic logic [1:0] next_rank(input logic [1:0] n, input logic [3:0] z);
    logic [1:0] r;
    r = 2'd0;
    case (n)
      2'd1:    r = z[2] ? 2'd2 : z[3] ? 2'd3 : z[1] ? 2'd1 : 2'd0;
      2'd2:    r = z[3] ? 2'd3 : z[1] ? 2'd1 : z[2] ? 2'd2 : 2'd0;
      2'd3:    r = z[1] ? 2'd1 : z[2] ? 2'd2 : z[3] ? 2'd3 : 2'd0;
      default: r = z[1] ? 2'd1 : z[2] ? 2'd2 : z[3] ? 2'd3 : 2'd0;
    endcase
    return r;
  endfunction

  function automatic state_e idx_to_state(input logic [1:0] i);
    state_e s;
    case (i)
      2'd1:    s = RANK1;
      2'd2:    s = RANK2;
      2'd3:    s = RANK3;
      default: s = IDLE;
    endcase
    return s;
  endfunction

  // Prescaler, tick pulse and live-value shadow.
  always_comb begin
    presc_d  = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    tick_d   = (presc_d == PRESC_MAX);
    shadow_d = slv_reg0;
    valid_d  = 1'b1;
  end

  assign nz       = {slv_reg3 != 8'h00, slv_reg2 != 8'h00, slv_reg1 != 8'h00, 1'b0};
  // The first edge after reset only seeds the shadow.
  assign live_chg = valid_q && (slv_reg0 != shadow_q);
  assign rank_exp = tick_q && (hold_q >= RANK_LAST);
  assign live_exp = tick_q && (hold_q >= LIVE_LAST);

  always_comb begin
    case (state_q)
      RANK1:   cur_idx = 2'd1;
      RANK2:   cur_idx = 2'd2;
      RANK3:   cur_idx = 2'd3;
      default: cur_idx = 2'd0;
    endcase
  end

  // Next-state, hold counter and return-rank logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ret_d   = ret_q;
    if (!en) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_d  = '0;
          state_d = idx_to_state(next_rank(2'd0, nz));
        end
        RANK1, RANK2, RANK3: begin
          if (nz == 4'd0) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (live_chg) begin
            state_d = LIVE;
            hold_d  = '0;
            ret_d   = rank_exp ? next_rank(cur_idx, nz) : cur_idx;
          end else if (rank_exp) begin
            state_d = idx_to_state(next_rank(cur_idx, nz));
            hold_d  = '0;
          end else if (tick_q) begin
            hold_d = hold_q + HW'(1);
          end
        end
        LIVE: begin
          if (live_chg) begin
            hold_d = '0;
          end else if (live_exp) begin
            state_d = idx_to_state(nz[ret_q] ? ret_q : next_rank(ret_q, nz));
            hold_d  = '0;
          end else if (tick_q) begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Display outputs follow the next state so they change on the same edge.
  always_comb begin
    case (state_d)
      RANK1:   disp_sel_d = 2'd1;
      RANK2:   disp_sel_d = 2'd2;
      RANK3:   disp_sel_d = 2'd3;
      default: disp_sel_d = 2'd0;
    endcase
    case (disp_sel_d)
      2'd1:    disp_data_d = slv_reg1;
      2'd2:    disp_data_d = slv_reg2;
      2'd3:    disp_data_d = slv_reg3;
      default: disp_data_d = slv_reg0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      hold_q      <= '0;
      ret_q       <= 2'd1;
      shadow_q    <= 8'h00;
      valid_q     <= 1'b0;
      disp_data_q <= 8'h00;
      disp_sel_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      ret_q       <= ret_d;
      shadow_q    <= shadow_d;
      valid_q     <= valid_d;
      disp_data_q <= disp_data_d;
      disp_sel_q  <= disp_sel_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_sel  = disp_sel_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_fnd_rank_scheduler.sv
// Directed bench for fnd_rank_scheduler with TICK_DIV=4, RANK_HOLD=2, LIVE_HOLD=3.
module tb_fnd_rank_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [7:0] disp_data;
  logic [1:0] disp_sel;
  logic       tick;

  int n_checks = 0;
  int n_pass   = 0;

  fnd_rank_scheduler #(
    .TICK_DIV (4),
    .RANK_HOLD(2),
    .LIVE_HOLD(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .slv_reg0 (slv_reg0),
    .slv_reg1 (slv_reg1),
    .slv_reg2 (slv_reg2),
    .slv_reg3 (slv_reg3),
    .disp_data(disp_data),
    .disp_sel (disp_sel),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] exp);
    check(tag, {6'b0, disp_sel}, {6'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; en = 1'b0;
    slv_reg0 = 8'h11; slv_reg1 = 8'h21; slv_reg2 = 8'h22; slv_reg3 = 8'h23;
    #2;
    check("rst_data", disp_data, 8'h00);
    chk_sel("rst_sel", 2'd0);
    check("rst_tick", {7'b0, tick}, 8'h00);
    #10 reset = 1'b1;

    // Rotation 1,2,3,1
    step(1);  check("idle_data", disp_data, 8'h11); chk_sel("idle_sel", 2'd0);
    en = 1'b1;
    step(1);  chk_sel("r1_sel", 2'd1); check("r1_data", disp_data, 8'h21);
    step(1);  check("tick_hi", {7'b0, tick}, 8'h01);
    step(1);  check("tick_lo", {7'b0, tick}, 8'h00);
    step(3);  chk_sel("r1_hold", 2'd1);
    step(1);  chk_sel("r2_sel", 2'd2); check("r2_data", disp_data, 8'h22);
    step(7);  chk_sel("r2_hold", 2'd2);
    step(1);  chk_sel("r3_sel", 2'd3); check("r3_data", disp_data, 8'h23);
    step(8);  chk_sel("r1_wrap", 2'd1);
    step(8);  chk_sel("r2_again", 2'd2);
    slv_reg2 = 8'h2A;
    step(1);  check("track_data", disp_data, 8'h2A);

    // Live change in RANK2, extended by a second change
    slv_reg0 = 8'h42;
    step(1);  chk_sel("live_sel", 2'd0); check("live_data", disp_data, 8'h42);
    step(5);
    slv_reg0 = 8'h43;
    step(1);  check("live2_data", disp_data, 8'h43);
    step(4);  chk_sel("live_ext", 2'd0);
    step(7);  chk_sel("live_ext_end", 2'd0);
    step(1);  chk_sel("live_ret", 2'd2); check("live_ret_data", disp_data, 8'h2A);

    // Live change coincident with RANK1 expiry returns to RANK2
    step(8);  chk_sel("r3_b", 2'd3);
    step(8);  chk_sel("r1_b", 2'd1);
    step(7);
    slv_reg0 = 8'h44;
    step(1);  chk_sel("coin_live", 2'd0); check("coin_data", disp_data, 8'h44);
    step(11); chk_sel("coin_hold", 2'd0);
    step(1);  chk_sel("coin_ret", 2'd2);

    // Live change together with en fall goes to IDLE only
    step(1);
    slv_reg0 = 8'h45; en = 1'b0;
    step(1);  chk_sel("en_off_sel", 2'd0); check("en_off_data", disp_data, 8'h45);
    en = 1'b1;
    step(1);  chk_sel("no_live", 2'd1);
    step(4);  chk_sel("r1_part", 2'd1);
    step(1);  chk_sel("r2_part", 2'd2);

    // Skip zero rank 2
    en = 1'b0; slv_reg2 = 8'h00;
    step(1);  chk_sel("idle2", 2'd0);
    en = 1'b1;
    step(1);  chk_sel("skip_r1", 2'd1);
    step(6);  chk_sel("skip_r3", 2'd3); check("skip_data", disp_data, 8'h23);
    step(8);  chk_sel("skip_r1b", 2'd1);
    step(8);  chk_sel("skip_r3b", 2'd3);
    slv_reg1 = 8'h00;
    step(8);  chk_sel("only_r3", 2'd3);
    step(8);  chk_sel("only_r3b", 2'd3);
    slv_reg3 = 8'h00;
    step(1);  chk_sel("all0_sel", 2'd0); check("all0_data", disp_data, 8'h45);
    step(3);  chk_sel("all0_stay", 2'd0);

    // Reset inside LIVE
    slv_reg0 = 8'h11; slv_reg1 = 8'h21; slv_reg2 = 8'h22; slv_reg3 = 8'h23;
    step(1);  chk_sel("idle_live_ign", 2'd1); check("idle_r1_data", disp_data, 8'h21);
    slv_reg0 = 8'h50;
    step(1);  chk_sel("live3_sel", 2'd0); check("live3_data", disp_data, 8'h50);
    #2 reset = 1'b0;
    #1;
    check("arst_data", disp_data, 8'h00);
    chk_sel("arst_sel", 2'd0);
    check("arst_tick", {7'b0, tick}, 8'h00);
    #2 reset = 1'b1;
    #1 chk_sel("rel_idle", 2'd0);
    step(1);  chk_sel("rel_r1", 2'd1); check("rel_data", disp_data, 8'h21);
    step(1);  chk_sel("rel_nolive", 2'd1); check("rel_tick0", {7'b0, tick}, 8'h00);
    step(1);  chk_sel("rel_nolive2", 2'd1); check("rel_tick1", {7'b0, tick}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
